seg7_output_driver: RTL

//   Output-side counterpart of the keypad input path: drives the 4-digit multiplexed
//   7-segment display on the board, reading a 16-bit hex value (4 nibbles) from core logic.

---
 rtl/seg7_output_driver_if.sv | 30 +++
 rtl/seg7_output_driver.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seg7_output_driver_if.sv
// ============================================================================
// Module      : seg7_output_driver_if
// Description : Core-side load bus and board-side display pins of the
//               4-digit multiplexed 7-segment driver.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seg7_output_driver_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        pending;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output load, value, dp_in, blank_lz,
        input  pending, an, seg, dp
    );

    modport slave (
        input  load, value, dp_in, blank_lz,
        output pending, an, seg, dp
    );
endinterface

`default_nettype wire

// File: rtl/seg7_output_driver.sv
// ============================================================================
// Module      : seg7_output_driver
// Description : Double-buffered 4-digit multiplexed 7-segment scanner with a
//               dead-time blank at the start of every digit slot.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_output_driver #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  wire logic            clk,
    input  wire logic            rst,
    seg7_output_driver_if.slave  bus
);

    localparam int               c_cnt_w     = $clog2(DIGIT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(DIGIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_blank_end = c_cnt_w'(BLANK_CYCLES);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [1:0]           r_idx;

    logic [15:0]          r_shadow_val;
    logic [3:0]           r_shadow_dp;
    logic                 r_shadow_lz;
    logic                 r_pending;

    logic [15:0]          r_act_val;
    logic [3:0]           r_act_dp;
    logic                 r_act_lz;

    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    logic                 r_dp;

    logic                 w_wrap;
    logic                 w_commit;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [3:0]           w_nib;
    logic [3:0]           w_lz_zero;
    logic                 w_digit_blank;
    logic                 w_dp_bit;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
    function automatic logic [6:0] dec7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_wrap    = (r_cnt == c_cnt_last);
    assign w_commit  = w_wrap && (r_idx == 2'd3);
    assign w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;

    always_comb begin
        w_nib    = r_act_val[3:0];
        w_dp_bit = r_act_dp[0];
        case (r_idx)
            2'd0: begin w_nib = r_act_val[3:0];   w_dp_bit = r_act_dp[0]; end
            2'd1: begin w_nib = r_act_val[7:4];   w_dp_bit = r_act_dp[1]; end
            2'd2: begin w_nib = r_act_val[11:8];  w_dp_bit = r_act_dp[2]; end
            default: begin w_nib = r_act_val[15:12]; w_dp_bit = r_act_dp[3]; end
        endcase
    end

    // w_lz_zero[i]: nibbles 3..i are all zero; digit0 is never a leading zero.
    assign w_lz_zero[3]  = (r_act_val[15:12] == 4'h0);
    assign w_lz_zero[2]  = w_lz_zero[3] && (r_act_val[11:8] == 4'h0);
    assign w_lz_zero[1]  = w_lz_zero[2] && (r_act_val[7:4] == 4'h0);
    assign w_lz_zero[0]  = 1'b0;
    assign w_digit_blank = r_act_lz && w_lz_zero[r_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_shadow_val <= 16'h0000;
            r_shadow_dp  <= 4'h0;
            r_shadow_lz  <= 1'b0;
            r_pending    <= 1'b0;
            r_act_val    <= 16'h0000;
            r_act_dp     <= 4'h0;
            r_act_lz     <= 1'b0;
            r_an         <= 4'b1111;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_wrap) begin
                r_idx <= r_idx + 2'd1;
            end
            r_state <= (w_cnt_nxt < c_blank_end) ? ST_BLANK : ST_SHOW;

            // A load landing on the commit cycle bypasses the shadow wait.
            if (w_commit) begin
                if (bus.load) begin
                    r_shadow_val <= bus.value;
                    r_shadow_dp  <= bus.dp_in;
                    r_shadow_lz  <= bus.blank_lz;
                    r_act_val    <= bus.value;
                    r_act_dp     <= bus.dp_in;
                    r_act_lz     <= bus.blank_lz;
                end else if (r_pending) begin
                    r_act_val    <= r_shadow_val;
                    r_act_dp     <= r_shadow_dp;
                    r_act_lz     <= r_shadow_lz;
                end
                r_pending <= 1'b0;
            end else if (bus.load) begin
                r_shadow_val <= bus.value;
                r_shadow_dp  <= bus.dp_in;
                r_shadow_lz  <= bus.blank_lz;
                r_pending    <= 1'b1;
            end

            case (r_state)
                ST_SHOW: begin
                    r_an  <= ~(4'b0001 << r_idx);
                    r_seg <= w_digit_blank ? 7'h7F : dec7(w_nib);
                    r_dp  <= ~w_dp_bit;
                end
                default: begin
                    r_an  <= 4'b1111;
                    r_seg <= 7'h7F;
                    r_dp  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pending = r_pending;
    assign bus.an      = r_an;
    assign bus.seg     = r_seg;
    assign bus.dp      = r_dp;

endmodule

`default_nettype wire
